// File: rtl/scl_pkg.sv
// rtl/scl_pkg.sv - state encoding and filter latency helper for the SCL timing engine
package scl_pkg;

  localparam int SCL_STATE_W = 3;

  typedef enum logic [SCL_STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_HIGH_WAIT = 3'd1,
    ST_HIGH      = 3'd2,
    ST_LOW       = 3'd3,
    ST_HOLD      = 3'd4
  } scl_state_t;

  // Cycles from a raw SCL change to the filtered value following it.
  function automatic int scl_latency(input int filter_len);
    return 2 + filter_len;
  endfunction

endpackage

// File: rtl/scl_input_filter.sv
// rtl/scl_input_filter.sv - 2-FF synchroniser plus stable-run filter for the raw SCL line
module scl_input_filter
  import scl_pkg::*;
#(
  parameter int FILTER_LEN = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_scl,
  output logic o_scl_filt_d
);

  localparam logic [2:0] LAST_IDX = 3'(FILTER_LEN - 1);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_filt;
  logic [2:0] r_run;
  logic       w_differ;
  logic       w_flip;

  // o_scl_filt_d is the value r_filt takes at the coming edge, so the FSM
  // reacts in the same cycle the filtered line changes.
  assign w_differ     = r_sync2 != r_filt;
  assign w_flip       = w_differ && (r_run == LAST_IDX);
  assign o_scl_filt_d = w_flip ? r_sync2 : r_filt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_filt  <= 1'b1;
      r_run   <= 3'd0;
    end else begin
      r_sync1 <= i_scl;
      r_sync2 <= r_sync1;
      r_filt  <= o_scl_filt_d;
      if (w_differ && !w_flip) begin
        r_run <= r_run + 3'd1;
      end else begin
        r_run <= 3'd0;
      end
    end
  end

endmodule

// File: rtl/scl_timing_engine.sv
// rtl/scl_timing_engine.sv - open-drain SCL generator with clock sync, stretch detect and hold
module scl_timing_engine
  import scl_pkg::*;
#(
  parameter int                   DIV_W       = 16,
  parameter int                   FILTER_LEN  = 3,
  parameter int                   TIMEOUT_W   = 20,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYC = TIMEOUT_W'(1000000)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_scl_en,
  input  logic             i_scl_wait,
  input  logic [DIV_W-1:0] i_scl_div_low,
  input  logic [DIV_W-1:0] i_scl_div_high,
  input  logic             i_scl_i,
  output logic             o_scl_o,
  output logic             o_scl_stretched,
  output logic             o_scl_rise,
  output logic             o_scl_fall,
  output logic             o_stretch_timeout,
  input  logic             i_timeout_clr
);

  localparam int                   L_CYC        = scl_latency(FILTER_LEN);
  localparam logic [TIMEOUT_W-1:0] SETTLE_CNT   = TIMEOUT_W'(L_CYC - 1);
  localparam logic [TIMEOUT_W-1:0] STRETCH_CNT  = TIMEOUT_W'(L_CYC);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_CYC - 1'b1;
  localparam logic [DIV_W-1:0]     DIV_ONE      = DIV_W'(1);

  scl_state_t           r_state;
  logic                 r_scl_o;
  logic                 r_stretched;
  logic                 r_rise;
  logic                 r_fall;
  logic                 r_timeout;
  logic [TIMEOUT_W-1:0] r_wait_cnt;
  logic [DIV_W-1:0]     r_phase_cnt;
  logic [DIV_W-1:0]     r_phase_len;

  logic                 w_scl_filt_d;
  logic [TIMEOUT_W-1:0] w_wait_nxt;
  logic [DIV_W-1:0]     w_phase_nxt;
  logic [DIV_W-1:0]     w_div_low_eff;
  logic [DIV_W-1:0]     w_div_high_eff;
  logic                 w_phase_done;
  logic                 w_settled;
  logic                 w_timeout_hit;

  scl_input_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_scl       (i_scl_i),
    .o_scl_filt_d(w_scl_filt_d)
  );

  assign w_wait_nxt     = (&r_wait_cnt) ? r_wait_cnt : r_wait_cnt + 1'b1;
  assign w_phase_nxt    = (&r_phase_cnt) ? r_phase_cnt : r_phase_cnt + 1'b1;
  assign w_div_low_eff  = (i_scl_div_low == '0) ? DIV_ONE : i_scl_div_low;
  assign w_div_high_eff = (i_scl_div_high == '0) ? DIV_ONE : i_scl_div_high;
  assign w_phase_done   = r_phase_cnt >= r_phase_len;
  // The filter pipeline still carries samples from before release for L cycles.
  assign w_settled      = r_wait_cnt >= SETTLE_CNT;
  assign w_timeout_hit  = (w_wait_nxt == TIMEOUT_LAST) && (r_wait_cnt != TIMEOUT_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_scl_o     <= 1'b1;
      r_stretched <= 1'b0;
      r_rise      <= 1'b0;
      r_fall      <= 1'b0;
      r_timeout   <= 1'b0;
      r_wait_cnt  <= '0;
      r_phase_cnt <= '0;
      r_phase_len <= '0;
    end else begin
      r_rise      <= 1'b0;
      r_fall      <= 1'b0;
      r_stretched <= 1'b0;
      if (i_timeout_clr) begin
        r_timeout <= 1'b0;
      end
      if (!i_scl_en) begin
        r_state     <= ST_IDLE;
        r_scl_o     <= 1'b1;
        r_wait_cnt  <= '0;
        r_phase_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state    <= ST_HIGH_WAIT;
            r_scl_o    <= 1'b1;
            r_wait_cnt <= '0;
          end
          ST_HIGH_WAIT: begin
            r_scl_o <= 1'b1;
            if (w_settled && w_scl_filt_d) begin
              r_state     <= ST_HIGH;
              r_rise      <= 1'b1;
              r_wait_cnt  <= '0;
              r_phase_cnt <= DIV_ONE;
              r_phase_len <= w_div_high_eff;
            end else begin
              r_wait_cnt  <= w_wait_nxt;
              r_stretched <= w_wait_nxt >= STRETCH_CNT;
              if (w_timeout_hit) begin
                r_timeout <= 1'b1;
              end
            end
          end
          ST_HIGH: begin
            // An early low from another master restarts our low phase at once.
            if (!w_scl_filt_d || w_phase_done) begin
              r_state     <= ST_LOW;
              r_scl_o     <= 1'b0;
              r_fall      <= 1'b1;
              r_phase_cnt <= DIV_ONE;
              r_phase_len <= w_div_low_eff;
            end else begin
              r_phase_cnt <= w_phase_nxt;
            end
          end
          ST_LOW: begin
            r_scl_o <= 1'b0;
            if (w_phase_done) begin
              r_wait_cnt <= '0;
              if (i_scl_wait) begin
                r_state <= ST_HOLD;
              end else begin
                r_state <= ST_HIGH_WAIT;
                r_scl_o <= 1'b1;
              end
            end else begin
              r_phase_cnt <= w_phase_nxt;
            end
          end
          ST_HOLD: begin
            r_wait_cnt <= '0;
            if (!i_scl_wait) begin
              r_state <= ST_HIGH_WAIT;
              r_scl_o <= 1'b1;
            end else begin
              r_scl_o <= 1'b0;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_scl_o <= 1'b1;
          end
        endcase
      end
    end
  end

  assign o_scl_o           = r_scl_o;
  assign o_scl_stretched   = r_stretched;
  assign o_scl_rise        = r_rise;
  assign o_scl_fall        = r_fall;
  assign o_stretch_timeout = r_timeout;

endmodule

// File: doc/scl_timing_engine.md
Name: scl_timing_engine

Overview:
Parametrised successor to the I2C SCL generator for the I2C_Controller master datapath.
- Drives open-drain SCL with independently programmable low and high phase lengths.
- Implements multi-master clock synchronisation over the wired-AND bus: an early low from another device restarts our low phase.
- Detects slave clock stretching, with a bounded timeout and a byte-level hold ("wait") request.
- Emits phase-edge strobes for the bit-level shifter.

Parameters:
DIV_W, 16, width of the phase divisor inputs.
FILTER_LEN, 3, consecutive equal synchronised samples needed to change the filtered SCL (range 1..7).
TIMEOUT_W, 20, width of the stretch timeout counter.
TIMEOUT_CYC, 20'd1000000, clk cycles spent in HIGH_WAIT before stretch_timeout sets.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
scl_en  in  1  enable; 0 forces IDLE and releases SCL
scl_wait  in  1  hold SCL low at the end of the current low phase while 1
scl_div_low  in  DIV_W  low phase length in clk cycles (0 treated as 1)
scl_div_high  in  DIV_W  high phase length in clk cycles, counted after SCL is observed high (0 treated as 1)
scl_i  in  1  raw bus SCL (asynchronous)
scl_o  out  1  open-drain control: 0 = pull low, 1 = release
scl_stretched  out  1  1 while SCL is released but held low externally beyond the filter latency
scl_rise  out  1  one-cycle strobe on entry to HIGH (data sample point)
scl_fall  out  1  one-cycle strobe on every entry to LOW
stretch_timeout  out  1  sticky flag; cleared by timeout_clr or rst
timeout_clr  in  1  clears stretch_timeout

Behaviour:
- Reset: scl_o=1; scl_stretched, scl_rise, scl_fall and stretch_timeout all 0; state IDLE; counters 0; filtered SCL 1; sync flops 1.
- Input path:
  - 2-FF synchroniser, then filter.
  - The filtered value flips only when the last FILTER_LEN synchronised samples all differ from it.
  - Latency from scl_i to the filtered value is L = 2 + FILTER_LEN cycles.
- States: IDLE, HIGH_WAIT, HIGH, LOW, HOLD.
  - IDLE: scl_o=1. scl_en=1 -> HIGH_WAIT on the next cycle.
  - HIGH_WAIT: scl_o=1; wait counter increments each cycle.
    - Filtered SCL=1 -> HIGH. Load the high counter; pulse scl_rise; clear the wait counter.
    - scl_stretched=1 while the wait counter >= L.
    - Wait counter == TIMEOUT_CYC-1 -> set stretch_timeout. The counter saturates and the FSM stays in HIGH_WAIT.
  - HIGH: scl_o=1.
    - Filtered SCL=0 before the count ends (another master pulled low) -> LOW immediately. Reload the low counter; pulse scl_fall.
    - Count reaches max(scl_div_high,1) cycles -> LOW; scl_o=0 on the next cycle; pulse scl_fall.
  - LOW: scl_o=0; counts max(scl_div_low,1) cycles.
    - At expiry with scl_wait=0 -> HIGH_WAIT.
    - At expiry with scl_wait=1 -> HOLD.
  - HOLD: scl_o=0 until scl_wait=0, then HIGH_WAIT on the next cycle.
- Divisors are sampled once, on entry to each phase; mid-phase changes take effect next phase.
- Nominal unstretched period: low = div_low cycles; high = L + div_high cycles (release to observed high, then counted high).
- scl_en=0 in any state -> IDLE next cycle with scl_o=1. An in-flight scl_fall/scl_rise is not generated.
- Simultaneous events:
  - rst overrides everything.
  - scl_en=0 overrides timeout and edge events.
  - timeout_clr and a timeout-set in the same cycle: the set wins.
- Counters saturate and never wrap.
- scl_rise and scl_fall are never high in the same cycle.

Decomposition:
- Package scl_pkg: state enum (IDLE, HIGH_WAIT, HIGH, LOW, HOLD), the encoded-width constant, and the L-latency function of FILTER_LEN.
- One sub-module, scl_input_filter (synchroniser plus stable-count filter, parameter FILTER_LEN), instantiated once.
- FSM and counters stay in the top module.

Test Plan:
All scenarios use DIV_W=8, FILTER_LEN=2 (L=4), scl_div_low=4, scl_div_high=4, bus = scl_o wired-AND with a bench-driven line.
- Free-run, no external drive -> scl_o low exactly 4 cycles, high 8 cycles. One scl_fall per low entry and one scl_rise per HIGH entry, 12 cycles apart.
- Slave holds the bus low 20 extra cycles after release -> scl_stretched rises 4 cycles after release and falls when filtered SCL=1. scl_rise arrives after the release; high time is still 4 counted cycles.
- Second master pulls SCL low at cycle 2 of HIGH -> scl_fall the cycle the filtered value drops; scl_o=0 for a full 4-cycle low phase; no extra scl_rise.
- scl_wait=1 asserted before low expiry, held 50 cycles -> scl_o stays 0 through HOLD. Release begins 1 cycle after scl_wait falls.
- TIMEOUT_CYC=30 with the bus held low forever -> stretch_timeout=1 on HIGH_WAIT cycle 30 and stays set. timeout_clr pulse -> 0. rst mid-LOW -> scl_o=1 on the next cycle, all flags 0.
- scl_div_low=0, scl_div_high=0 -> behaves as 1: low 1 cycle, high 5 cycles. scl_en dropped mid-HIGH -> IDLE with scl_o=1 and no strobes.
